tt10: RTL and testbench



---
 rtl/tt10_pkg.sv | 28 ++
 rtl/tt10_pwm_core.sv | 72 +++++++
 rtl/tt10.sv | 92 +++++++++
 tb/tb_tt10.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt10_pkg.sv
// tt10_pkg: shared constants for the tt10 two-channel PWM tile.
// Register map, CTRL bit positions, uo_out bit layout and reset value.
package tt10_pkg;

  // Register file addresses selected by ui_in[1:0]
  typedef enum logic [1:0] {
    ADDR_DUTY_A  = 2'd0,
    ADDR_DUTY_B  = 2'd1,
    ADDR_PRESCALE = 2'd2,
    ADDR_CTRL    = 2'd3
  } reg_addr_e;

  localparam int NUM_REGS = 4;

  // CTRL register bits; bits [7:2] are stored but have no effect
  localparam int CTRL_EN  = 0;
  localparam int CTRL_INV = 1;

  // uo_out layout in normal (status) mode
  localparam int UO_PWM_A   = 0;
  localparam int UO_PWM_B   = 1;
  localparam int UO_PULSE   = 2;
  localparam int UO_EN      = 3;
  localparam int UO_CNT_LSB = 4;

  localparam logic [7:0] REG_RST = 8'h00;

endpackage

// File: rtl/tt10_pwm_core.sv
// tt10_pwm_core: prescaler, shared 8-bit period counter, two duty
// comparators and the end-of-period pulse. All outputs are registered.
module tt10_pwm_core
  import tt10_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       inv_i,
  input  logic [7:0] duty_a_i,
  input  logic [7:0] duty_b_i,
  input  logic [7:0] prescale_i,
  output logic       pwm_a_o,
  output logic       pwm_b_o,
  output logic       pulse_o,
  output logic [7:0] cnt_o
);

  logic [7:0] psc_q, psc_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pwm_a_q, pwm_a_d;
  logic       pwm_b_q, pwm_b_d;
  logic       pulse_q, pulse_d;
  logic       tick;

  // '>=' rather than '==' so a PRESCALE lowered below the current psc
  // wraps on the next cycle instead of running psc all the way round.
  assign tick = (psc_q >= prescale_i);

  // Next-state: count while enabled, everything held at zero otherwise
  always_comb begin
    psc_d   = 8'h00;
    cnt_d   = 8'h00;
    pwm_a_d = 1'b0;
    pwm_b_d = 1'b0;
    pulse_d = 1'b0;
    if (en_i) begin
      if (tick) begin
        cnt_d   = cnt_q + 8'd1;
        pulse_d = (cnt_q == 8'hFF);
      end else begin
        psc_d = psc_q + 8'd1;
        cnt_d = cnt_q;
      end
      pwm_a_d = (cnt_q < duty_a_i) ^ inv_i;
      pwm_b_d = (cnt_q < duty_b_i) ^ inv_i;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psc_q   <= 8'h00;
      cnt_q   <= 8'h00;
      pwm_a_q <= 1'b0;
      pwm_b_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      psc_q   <= psc_d;
      cnt_q   <= cnt_d;
      pwm_a_q <= pwm_a_d;
      pwm_b_q <= pwm_b_d;
      pulse_q <= pulse_d;
    end
  end

  assign pwm_a_o = pwm_a_q;
  assign pwm_b_o = pwm_b_q;
  assign pulse_o = pulse_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/tt10.sv
// tt10: Tiny Tapeout tile top. Register file written by a rising-edge
// strobe on ui_in[7], PWM core, status/readback output mux, uio tie-offs.
// Optional feature macro: TT10_READBACK_EN (ui_in[6] selects register
// readback on uo_out, combinationally).
module tt10
  import tt10_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0] regs_q [NUM_REGS];
  logic       wr_prev_q;
  logic       wr_block_q;
  logic       wr_fire;
  logic       pwm_a, pwm_b, pulse;
  logic [7:0] cnt;
  logic [7:0] status;

  // A strobe that was already high when reset released is blocked until
  // it has been seen low, so a held strobe never causes a stray write.
  assign wr_fire = ui_in[7] & ~wr_prev_q & ~wr_block_q;

  // Strobe edge detect plus post-reset block for a strobe held through reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_prev_q  <= 1'b0;
      wr_block_q <= ui_in[7];
    end else begin
      wr_prev_q <= ui_in[7];
      if (!ui_in[7]) begin
        wr_block_q <= 1'b0;
      end
    end
  end

  // One register per address, loaded on the detected strobe edge
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        regs_q[gi] <= REG_RST;
      end else if (wr_fire && (ui_in[1:0] == 2'(gi))) begin
        regs_q[gi] <= uio_in;
      end
    end
  end

  tt10_pwm_core u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (regs_q[ADDR_CTRL][CTRL_EN]),
    .inv_i      (regs_q[ADDR_CTRL][CTRL_INV]),
    .duty_a_i   (regs_q[ADDR_DUTY_A]),
    .duty_b_i   (regs_q[ADDR_DUTY_B]),
    .prescale_i (regs_q[ADDR_PRESCALE]),
    .pwm_a_o    (pwm_a),
    .pwm_b_o    (pwm_b),
    .pulse_o    (pulse),
    .cnt_o      (cnt)
  );

  // Normal-mode status word assembled from the core outputs
  always_comb begin
    status                       = 8'h00;
    status[UO_PWM_A]             = pwm_a;
    status[UO_PWM_B]             = pwm_b;
    status[UO_PULSE]             = pulse;
    status[UO_EN]                = regs_q[ADDR_CTRL][CTRL_EN];
    status[UO_CNT_LSB +: 4]      = cnt[7:4];
  end

`ifdef TT10_READBACK_EN
  assign uo_out = ui_in[6] ? regs_q[ui_in[1:0]] : status;
`else
  assign uo_out = status;
`endif

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // Inputs and register bits with no function in this design
  logic unused_bits;
  assign unused_bits = &{1'b0, ena, ui_in[6:2], cnt[3:0],
                         regs_q[ADDR_CTRL][7:2]};

endmodule

// File: tb/tb_tt10.sv
// tb_tt10: directed self-checking bench for tt10.
module tb_tt10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tt10 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  typedef struct {
    logic [7:0] da;
    logic [7:0] db;
    logic [7:0] psc;
    logic [7:0] ctrl;
    int         win;
    int         exp_a;
    int         exp_b;
    int         exp_p;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    ui_in  = {2'b10, 4'b0000, a};
    uio_in = d;
    @(negedge clk);
    ui_in = 8'h00;
    @(negedge clk);
  endtask

  task automatic count_win(input int win, output int ha, output int hb, output int np);
    ha = 0; hb = 0; np = 0;
    for (int i = 0; i < win; i++) begin
      @(negedge clk);
      ha += int'(uo_out[0]);
      hb += int'(uo_out[1]);
      np += int'(uo_out[2]);
    end
  endtask

  // Waits for the period pulse; returns cycles waited or -1 on timeout
  task automatic wait_pulse(input int limit, output int waited);
    waited = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (uo_out[2]) begin
        waited = i;
        break;
      end
    end
  endtask

  initial begin
    int ha, hb, np, w, ok_all;

    vecs[0] = '{8'h40, 8'hC0, 8'd0, 8'h01, 256,  64,  192, 1};
    vecs[1] = '{8'h40, 8'hC0, 8'd3, 8'h03, 1024, 768, 256, 1};
    vecs[2] = '{8'h00, 8'hFF, 8'd0, 8'h01, 256,  0,   255, 1};
    vecs[3] = '{8'h00, 8'hFF, 8'd0, 8'h03, 256,  256, 1,   1};
    vecs[4] = '{8'h80, 8'h01, 8'd1, 8'h01, 512,  256, 2,   1};

    // Reset held 5 cycles with a CTRL=0x01 strobe asserted throughout
    ena    = 1'b1;
    rst_n  = 1'b0;
    ui_in  = 8'h83;
    uio_in = 8'h01;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset uo_out", uo_out, 8'h00);
    check("reset uio_oe", uio_oe, 8'h00);
    check("reset uio_out", uio_out, 8'h00);
    repeat (3) @(negedge clk);
    check("held strobe after reset no write", uo_out, 8'h00);
    ui_in = 8'h00;
    @(negedge clk);
    wr(2'd3, 8'h01);
    check("write after strobe re-rise EN", int'(uo_out[3]), 1);

    // Table-driven PWM vectors
    foreach (vecs[k]) begin
      wr(2'd0, vecs[k].da);
      wr(2'd1, vecs[k].db);
      wr(2'd2, vecs[k].psc);
      wr(2'd3, vecs[k].ctrl);
      repeat (16) @(negedge clk);
      check($sformatf("v%0d EN bit", k), int'(uo_out[3]), int'(vecs[k].ctrl[0]));
      count_win(vecs[k].win, ha, hb, np);
      check($sformatf("v%0d pwm_a highs", k), ha, vecs[k].exp_a);
      check($sformatf("v%0d pwm_b highs", k), hb, vecs[k].exp_b);
      check($sformatf("v%0d pulses", k), np, vecs[k].exp_p);
      if (k == 1) begin
        wait_pulse(2000, w);
        check("v1 first pulse seen", int'(w > 0), 1);
        wait_pulse(2000, w);
        check("v1 pulse spacing", w, 1024);
      end
    end

    // Disable while cnt = 0x80
    wr(2'd2, 8'd0);
    wr(2'd3, 8'h01);
    w = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (uo_out[7:4] == 4'h8) begin
        w = i;
        break;
      end
    end
    check("reach cnt 0x80", int'(w >= 0), 1);
    ui_in  = 8'h83;
    uio_in = 8'h00;
    @(negedge clk);
    ui_in = 8'h00;
    check("disable EN bit", int'(uo_out[3]), 0);
    @(negedge clk);
    check("disable uo_out next cycle", uo_out, 8'h00);
    ok_all = 1;
    repeat (20) begin
      @(negedge clk);
      if (uo_out != 8'h00) ok_all = 0;
    end
    check("disable stays zero", ok_all, 1);

    // Strobe held 10 cycles at addr 0 with changing data
    @(negedge clk);
    ui_in  = 8'h80;
    uio_in = 8'h10;
    repeat (3) @(negedge clk);
    uio_in = 8'h20;
    repeat (3) @(negedge clk);
    uio_in = 8'h30;
    repeat (4) @(negedge clk);
    ui_in = 8'h00;
    wr(2'd1, 8'h00);
    wr(2'd3, 8'h01);
    repeat (16) @(negedge clk);
    count_win(256, ha, hb, np);
    check("held strobe duty_a highs", ha, 16);
    check("held strobe duty_b highs", hb, 0);

    // Readback select
    wr(2'd2, 8'h5A);
    @(negedge clk);
    ui_in = 8'h42;
    #1;
`ifdef TT10_READBACK_EN
    check("readback PRESCALE", uo_out, 8'h5A);
    ui_in = 8'h43;
    #1;
    check("readback CTRL", uo_out, 8'h01);
    ui_in = 8'h40;
    #1;
    check("readback DUTY_A", uo_out, 8'h10);
`else
    check("no readback EN bit", int'(uo_out[3]), 1);
    ui_in = 8'h43;
    #1;
    check("no readback CTRL addr EN bit", int'(uo_out[3]), 1);
`endif
    @(negedge clk);
    ui_in = 8'h00;

    // Reset mid-run with a CTRL write strobe held through it
    @(negedge clk);
    rst_n  = 1'b0;
    ui_in  = 8'h83;
    uio_in = 8'h01;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid-run reset uo_out", uo_out, 8'h00);
    ok_all = 1;
    repeat (4) begin
      @(negedge clk);
      if (uo_out != 8'h00) ok_all = 0;
    end
    check("mid-run reset held strobe no write", ok_all, 1);
    ui_in = 8'h00;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
